// File: rtl/occ_line_cache_if.sv
// AXI4-Lite read-only channel bundle (AR + R) carrying whole Occ lines.
// The master issues addresses and accepts data; the slave answers.
interface occ_line_cache_if #(
  parameter int AW = 40,
  parameter int DW = 256
);
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/occ_line_cache.sv
// Read-only direct-mapped cache of 256-bit Occ lines between the seek engine and memory.
// Hits are answered from on-chip RAM two cycles after the address handshake.
module occ_line_cache #(
  parameter int AW    = 40,
  parameter int DW    = 256,
  parameter int LINES = 64,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  occ_line_cache_if.slave   s_axi,
  occ_line_cache_if.master  m_axi,
  input  logic              inv_i,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o,
  output logic              s_awready_o,
  output logic              s_wready_o,
  output logic              s_bvalid_o
);

  localparam int OB  = $clog2(DW / 8);
  localparam int IW  = $clog2(LINES);
  localparam int LAW = AW - OB;
  localparam int TW  = LAW - IW;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, MISS_R, RESP} state_e;

  state_e           state_q, state_d;
  logic [LAW-1:0]   lineAddr_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tagRam  [LINES];
  logic [DW-1:0]    dataRam [LINES];
  logic [TW-1:0]    rdTag_q;
  logic [DW-1:0]    rdData_q;
  logic [DW-1:0]    sRdata_q;
  logic [1:0]       sRresp_q;
  logic [CNT_W-1:0] hitCnt_q, missCnt_q;

  logic          arReady, sRvalid, mArvalid, mRready;
  logic          arHs, lookupHit, hitInc, missInc, fillWe, loadHit, loadMiss;
  logic [IW-1:0] rdIdx, curIdx;
  logic [TW-1:0] curTag;
  logic          unused_addrLow;

  assign rdIdx          = s_axi.araddr[OB +: IW];
  assign curIdx         = lineAddr_q[IW-1:0];
  assign curTag         = lineAddr_q[LAW-1:IW];
  assign arHs           = arReady && s_axi.arvalid;
  assign lookupHit      = valid_q[curIdx] && (rdTag_q == curTag);
  assign unused_addrLow = ^s_axi.araddr[OB-1:0];

  always_comb begin
    state_d  = state_q;
    arReady  = 1'b0;
    sRvalid  = 1'b0;
    mArvalid = 1'b0;
    mRready  = 1'b0;
    hitInc   = 1'b0;
    missInc  = 1'b0;
    fillWe   = 1'b0;
    loadHit  = 1'b0;
    loadMiss = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          arReady = 1'b1;
          if (s_axi.arvalid) state_d = LOOKUP;
        end
        LOOKUP: begin
          if (lookupHit) begin
            hitInc  = 1'b1;
            loadHit = 1'b1;
            state_d = RESP;
          end else begin
            missInc = 1'b1;
            state_d = MISS_AR;
          end
        end
        MISS_AR: begin
          mArvalid = 1'b1;
          if (m_axi.arready) state_d = MISS_R;
        end
        MISS_R: begin
          mRready = 1'b1;
          if (m_axi.rvalid) begin
            loadMiss = 1'b1;
            fillWe   = (m_axi.rresp == RESP_OKAY);
            state_d  = RESP;
          end
        end
        RESP: begin
          sRvalid = 1'b1;
          if (s_axi.rready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lineAddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (arHs) lineAddr_q <= s_axi.araddr[AW-1:OB];
    end
  end

  // Tag/data RAM read is launched by the address handshake so LOOKUP sees it registered.
  always_ff @(posedge clk) begin
    if (arHs) begin
      rdTag_q  <= tagRam[rdIdx];
      rdData_q <= dataRam[rdIdx];
    end
    if (fillWe) begin
      tagRam[curIdx]  <= curTag;
      dataRam[curIdx] <= m_axi.rdata;
    end
  end

  // Invalidate beats a simultaneous fill, so a line filled during inv stays invalid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (inv_i) begin
      valid_q <= '0;
    end else if (fillWe) begin
      valid_q[curIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sRdata_q <= '0;
      sRresp_q <= '0;
    end else if (loadHit) begin
      sRdata_q <= rdData_q;
      sRresp_q <= RESP_OKAY;
    end else if (loadMiss) begin
      sRdata_q <= m_axi.rdata;
      sRresp_q <= m_axi.rresp;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || cnt_clr_i) begin
      hitCnt_q  <= '0;
      missCnt_q <= '0;
    end else begin
      if (hitInc)  hitCnt_q  <= hitCnt_q + CNT_W'(1);
      if (missInc) missCnt_q <= missCnt_q + CNT_W'(1);
    end
  end

  assign s_axi.arready = arReady;
  assign s_axi.rvalid  = sRvalid;
  assign s_axi.rdata   = sRdata_q;
  assign s_axi.rresp   = sRresp_q;
  assign m_axi.arvalid = mArvalid;
  assign m_axi.araddr  = {lineAddr_q, {OB{1'b0}}};
  assign m_axi.rready  = mRready;
  assign hit_cnt_o     = hitCnt_q;
  assign miss_cnt_o    = missCnt_q;
  assign s_awready_o   = 1'b0;
  assign s_wready_o    = 1'b0;
  assign s_bvalid_o    = 1'b0;

endmodule

// File: tb/tb_occ_line_cache.sv
// Bench for occ_line_cache: directed vector table, then random reads against a
// line-granular reference model of the cache and a latency-randomised memory slave.
module tb_occ_line_cache;

  localparam int AW = 40;
  localparam int DW = 256;
  localparam int LINES = 64;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic inv = 1'b0;
  logic cntClr = 1'b0;
  logic [CNT_W-1:0] hitCnt, missCnt;
  logic awReady, wReady, bValid;

  occ_line_cache_if #(.AW(AW), .DW(DW)) up ();
  occ_line_cache_if #(.AW(AW), .DW(DW)) dn ();

  occ_line_cache #(.AW(AW), .DW(DW), .LINES(LINES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .s_axi(up.slave), .m_axi(dn.master),
    .inv_i(inv), .cnt_clr_i(cntClr), .hit_cnt_o(hitCnt), .miss_cnt_o(missCnt),
    .s_awready_o(awReady), .s_wready_o(wReady), .s_bvalid_o(bValid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one valid/tag entry per line index plus expected counters.
  bit [LINES-1:0] refValid;
  logic [28:0] refTag [LINES];
  int refHits, refMisses;

  // Memory slave state.
  logic memBusy;
  logic [39:0] memAddr;
  int memLat;
  int mArCount = 0;

  function automatic logic [1:0] respOf(input logic [34:0] line);
    if (line == 35'd4) return 2'b10;
    if (line == 35'd7) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [255:0] memData(input logic [34:0] line);
    logic [255:0] d;
    for (int k = 0; k < 8; k++)
      d[k*32 +: 32] = line[31:0] * 32'h9E3779B1 + 32'(k) * 32'h01234567 + {29'd0, line[34:32]};
    return d;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      memBusy    <= 1'b0;
      memLat     <= 0;
      dn.arready <= 1'b0;
      dn.rvalid  <= 1'b0;
      dn.rdata   <= '0;
      dn.rresp   <= 2'b00;
    end else if (!memBusy) begin
      if (dn.arvalid && dn.arready) begin
        memBusy    <= 1'b1;
        memAddr    <= dn.araddr;
        memLat     <= int'($urandom_range(0, 3));
        dn.arready <= 1'b0;
        mArCount   <= mArCount + 1;
      end else begin
        dn.arready <= ($urandom_range(0, 2) != 0);
      end
    end else if (!dn.rvalid) begin
      if (memLat == 0) begin
        dn.rvalid <= 1'b1;
        dn.rresp  <= respOf(memAddr[39:5]);
        dn.rdata  <= (respOf(memAddr[39:5]) == 2'b00) ? memData(memAddr[39:5]) : '0;
      end else begin
        memLat <= memLat - 1;
      end
    end else if (dn.rready) begin
      dn.rvalid <= 1'b0;
      memBusy   <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clearModel();
    refValid  = '0;
    refHits   = 0;
    refMisses = 0;
  endtask

  task automatic doReset();
    reset_n    = 1'b0;
    up.arvalid = 1'b0;
    up.rready  = 1'b0;
    inv        = 1'b0;
    cntClr     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstArReady", 256'(up.arready), 256'(0));
    checkOutput("rstRValid", 256'(up.rvalid), 256'(0));
    checkOutput("rstMArValid", 256'(dn.arvalid), 256'(0));
    checkOutput("rstMRReady", 256'(dn.rready), 256'(0));
    checkOutput("rstRData", up.rdata, 256'(0));
    checkOutput("rstRResp", 256'(up.rresp), 256'(0));
    checkOutput("rstMArAddr", 256'(dn.araddr), 256'(0));
    checkOutput("rstHitCnt", 256'(hitCnt), 256'(0));
    checkOutput("rstMissCnt", 256'(missCnt), 256'(0));
    reset_n = 1'b1;
    clearModel();
    @(negedge clk);
  endtask

  // mode: 0 plain, 1 inv in LOOKUP, 2 inv in the fill cycle, 3 cnt_clr in LOOKUP.
  task automatic applyStimulus(input logic [39:0] addr, input int mode,
                               output bit gotHit, output logic [1:0] gotResp);
    logic [34:0] line;
    logic [5:0] idx;
    logic [28:0] tag;
    bit expHit, pulsed;
    logic [1:0] expResp;
    logic [255:0] expData;
    int arBefore, n, c;
    line = addr[39:5];
    idx = addr[10:5];
    tag = addr[39:11];
    expHit = refValid[idx] && (refTag[idx] == tag);
    expResp = expHit ? 2'b00 : respOf(line);
    expData = (expResp == 2'b00) ? memData(line) : '0;
    arBefore = mArCount;
    gotHit = 1'b0;
    gotResp = 2'b00;
    up.arvalid = 1'b1;
    up.araddr = addr;
    n = 0;
    while (!up.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checkOutput("arReadyTimeout", 256'(0), 256'(1));
      up.arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    up.arvalid = 1'b0;
    c = 0;
    pulsed = 1'b0;
    while (!up.rvalid && c < 200) begin
      if (c == 0 && mode == 1) begin inv = 1'b1; pulsed = 1'b1; end
      if (c == 0 && mode == 3) begin cntClr = 1'b1; pulsed = 1'b1; end
      if (mode == 2 && !pulsed && dn.rvalid && dn.rready) begin inv = 1'b1; pulsed = 1'b1; end
      @(negedge clk);
      inv = 1'b0;
      cntClr = 1'b0;
      c++;
    end
    if (c >= 200) begin
      checkOutput("rValidTimeout", 256'(0), 256'(1));
      return;
    end
    if (expHit) refHits++; else refMisses++;
    if (mode == 3 && pulsed) begin refHits = 0; refMisses = 0; end
    if (pulsed && (mode == 1 || mode == 2)) refValid = '0;
    if (!expHit && expResp == 2'b00 && !(mode == 2 && pulsed)) begin
      refValid[idx] = 1'b1;
      refTag[idx] = tag;
    end
    if (expHit) checkOutput("hitLatency", 256'(c), 256'(1));
    checkOutput("mArCount", 256'(mArCount - arBefore), 256'(expHit ? 0 : 1));
    if (!expHit) checkOutput("mArAddr", 256'(memAddr), 256'({addr[39:5], 5'b0}));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    checkOutput("rValidHeld", 256'(up.rvalid), 256'(1));
    checkOutput("rData", up.rdata, expData);
    checkOutput("rResp", 256'(up.rresp), 256'(expResp));
    gotHit = (mArCount == arBefore);
    gotResp = up.rresp;
    up.rready = 1'b1;
    @(negedge clk);
    up.rready = 1'b0;
    checkOutput("arReadyAfterResp", 256'(up.arready), 256'(1));
    checkOutput("hitCnt", 256'(hitCnt), 256'(refHits));
    checkOutput("missCnt", 256'(missCnt), 256'(refMisses));
  endtask

  typedef struct {
    logic [39:0] addr;
    int          mode;
    bit          expHit;
    logic [1:0]  expResp;
  } vec_t;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[$];
    bit gotHit;
    logic [1:0] gotResp;
    logic [39:0] a;
    int r, mode, n;

    up.arvalid = 1'b0;
    up.araddr  = '0;
    up.rready  = 1'b0;

    vecs.push_back('{40'h40,  0, 1'b0, 2'b00});
    vecs.push_back('{40'h5F,  0, 1'b1, 2'b00});
    for (int i = 0; i < 4; i++) begin
      vecs.push_back('{40'h840, 0, 1'b0, 2'b00});
      vecs.push_back('{40'h40,  0, 1'b0, 2'b00});
    end
    vecs.push_back('{40'h80,  0, 1'b0, 2'b10});
    vecs.push_back('{40'h80,  0, 1'b0, 2'b10});
    vecs.push_back('{40'h100, 2, 1'b0, 2'b00});
    vecs.push_back('{40'h100, 0, 1'b0, 2'b00});
    vecs.push_back('{40'h11F, 0, 1'b1, 2'b00});
    vecs.push_back('{40'h100, 1, 1'b1, 2'b00});
    vecs.push_back('{40'h100, 0, 1'b0, 2'b00});
    vecs.push_back('{40'h100, 3, 1'b1, 2'b00});
    vecs.push_back('{40'h40,  0, 1'b0, 2'b00});
    vecs.push_back('{40'hE0,  0, 1'b0, 2'b11});

    doReset();
    checkOutput("awReady", 256'(awReady), 256'(0));
    checkOutput("wReady", 256'(wReady), 256'(0));
    checkOutput("bValid", 256'(bValid), 256'(0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].mode, gotHit, gotResp);
      checkOutput($sformatf("vecHit%0d", i), 256'(gotHit), 256'(vecs[i].expHit));
      checkOutput($sformatf("vecResp%0d", i), 256'(gotResp), 256'(vecs[i].expResp));
    end

    // Reset while a miss is outstanding: the access is dropped and the cache is cold again.
    up.arvalid = 1'b1;
    up.araddr = 40'h200;
    n = 0;
    while (!up.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    up.arvalid = 1'b0;
    repeat (3) @(negedge clk);
    doReset();
    applyStimulus(40'h200, 0, gotHit, gotResp);
    checkOutput("postResetMiss", 256'(gotHit), 256'(0));

    for (int i = 0; i < 200; i++) begin
      a = (40'($urandom_range(0, 3)) << 11) | (40'($urandom_range(0, 7)) << 5)
        | 40'($urandom_range(0, 31));
      r = int'($urandom_range(0, 9));
      mode = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
      if ($urandom_range(0, 19) == 0) begin
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        refValid = '0;
      end
      applyStimulus(a, mode, gotHit, gotResp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
